sr_mdu: RTL
===========

// Module: sr_mdu
//
// PURPOSE
//   Iterative multiply/divide unit for the RV32M extension of schoolRISCV.
//   It sits next to the single-cycle ALU in the execute stage.
//   It accepts one operation per start pulse, runs a radix-2 shift-add or
//   shift-subtract loop, and returns a 32-bit result with a one-cycle done
//   pulse. The control unit stalls the PC and register-file write while busy=1.
//
// PARAMETERS
//   none (datapath fixed at 32 bits, matching the RV32 register file)
//
// PORTS
//   clk      in   1   core clock, all state updates on rising edge
//   rst      in   1   synchronous reset, active high
//   start    in   1   request strobe; sampled only in IDLE or DONE
//   oper     in   3   funct3: 0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
//   srcA     in   32  rs1 operand (multiplicand / dividend)
//   srcB     in   32  rs2 operand (multiplier / divisor)
//   busy     out  1   operation in progress; core must hold operands stable-free (latched)
//   done     out  1   one-cycle pulse: result valid this cycle
//   result   out  32  registered result; holds last value until next completion
//
// BEHAVIOUR
//   Reset: state=IDLE, busy=0, done=0, result=32'h0. Applies mid-operation:
//     the in-flight op is abandoned, no done pulse is produced.
//   States: IDLE -> RUN -> FIX -> DONE -> IDLE. A fast path goes IDLE/DONE -> DONE.
//   Accept: start=1 in IDLE or DONE latches oper, srcA and srcB at that edge.
//     start in RUN or FIX is ignored (not queued).
//   Operand prep: signed ops take magnitudes and record the result sign.
//     MULH: both operands signed. MULHSU: A signed, B unsigned. DIV/REM: both signed.
//   RUN: exactly 32 iterations, one per cycle, driven by a 5-bit counter 31..0.
//     MUL*: 64-bit product accumulator, add-if-LSB then shift right.
//     DIV*: restoring division, 64-bit {rem,quot} shift-left, trial subtract.
//   FIX: one cycle. Applies two's-complement negation where needed.
//     Quotient sign = signA^signB. Remainder sign = signA (RISC-V rule).
//     Selects the output: MUL low word; MULH/MULHSU/MULHU high word; DIV* quotient; REM* remainder.
//   Latency, start accepted at edge ending cycle k:
//     busy=1 in cycles k+1..k+33; done=1 and busy=0 in cycle k+34.
//   Fast path: divisor==0 or signed overflow skips RUN/FIX. done=1 in cycle k+1.
//     div-by-zero: DIV/DIVU quotient = 32'hFFFFFFFF, REM/REMU remainder = srcA.
//     overflow (DIV/REM, srcA=32'h80000000, srcB=32'hFFFFFFFF):
//       quotient = 32'h80000000, remainder = 0.
//   MUL by zero takes the normal 34-cycle path; latency does not depend on data except the fast path.
//   Back-to-back: start in the DONE cycle is accepted. The next done arrives 34 cycles later.
//   done never asserts in two consecutive cycles, except for back-to-back fast-path ops.
//   result updates only on the cycle done rises; busy and done are never both 1.
//
// TESTING
//   MUL 7 x -3 (srcB=32'hFFFFFFFD) -> done at k+34, result=32'hFFFFFFEB, busy high 33 cycles
//   MULHU 32'hFFFFFFFF x 32'hFFFFFFFF -> result=32'hFFFFFFFE; MULH same -> 32'h00000000
//   DIV -7/2 -> 32'hFFFFFFFD; REM -7/2 -> 32'hFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2
//   DIVU 5/0 -> done at k+1, result=32'hFFFFFFFF; REM 5/0 -> 5; DIV 32'h80000000/-1 -> 32'h80000000
//   start pulsed during RUN -> ignored, original op result returned at k+34; start in DONE -> new op accepted
//   rst asserted at k+10 of a DIV -> busy=0, done=0, result=0 next cycle; no spurious done afterward

Source files
------------

// File: rtl/sr_mdu.sv
// Iterative RV32M multiply/divide unit: 32-step radix-2 shift-add multiply and
// restoring divide, with a single-cycle fast path for divide-by-zero and signed overflow.
module sr_mdu (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [2:0]  i_oper,
  input  logic [31:0] i_src_a,
  input  logic [31:0] i_src_b,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_result
);

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e      r_state, w_state_next;
  logic [2:0]  r_oper;
  logic [63:0] r_acc;
  logic [31:0] r_div;
  logic [4:0]  r_cnt;
  logic        r_neg_q, r_neg_r;
  logic [31:0] r_result;

  logic        w_accept, w_sign_a, w_sign_b, w_div_zero, w_ovf, w_fast;
  logic [31:0] w_mag_a, w_mag_b, w_fast_res;
  logic [32:0] w_mul_sum, w_rem_sh, w_diff;
  logic [63:0] w_mul_next, w_div_next, w_prod;
  logic [31:0] w_quot, w_rem, w_fix_res;

  assign w_accept = i_start && (r_state == StIdle || r_state == StDone);

  // MULH, MULHSU, DIV and REM treat rs1 as signed; MULH, DIV and REM also rs2.
  assign w_sign_a = i_src_a[31] && (i_oper == 3'd1 || i_oper == 3'd2 ||
                                    i_oper == 3'd4 || i_oper == 3'd6);
  assign w_sign_b = i_src_b[31] && (i_oper == 3'd1 || i_oper == 3'd4 || i_oper == 3'd6);
  assign w_mag_a  = w_sign_a ? (32'd0 - i_src_a) : i_src_a;
  assign w_mag_b  = w_sign_b ? (32'd0 - i_src_b) : i_src_b;

  assign w_div_zero = i_oper[2] && (i_src_b == 32'd0);
  assign w_ovf      = i_oper[2] && !i_oper[0] &&
                      (i_src_a == 32'h8000_0000) && (i_src_b == 32'hFFFF_FFFF);
  assign w_fast     = w_div_zero || w_ovf;
  // i_oper[1] separates REM* from DIV* within the divide group.
  assign w_fast_res = w_div_zero ? (i_oper[1] ? i_src_a : 32'hFFFF_FFFF)
                                 : (i_oper[1] ? 32'd0 : 32'h8000_0000);

  assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_div} : 33'd0);
  assign w_mul_next = {w_mul_sum, r_acc[31:1]};

  // Partial remainder fits 33 bits after the shift; bit 32 of the difference is the borrow.
  assign w_rem_sh   = r_acc[63:31];
  assign w_diff     = w_rem_sh - {1'b0, r_div};
  assign w_div_next = w_diff[32] ? {w_rem_sh[31:0], r_acc[30:0], 1'b0}
                                 : {w_diff[31:0], r_acc[30:0], 1'b1};

  assign w_prod = r_neg_q ? (64'd0 - r_acc) : r_acc;
  assign w_quot = r_neg_q ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
  assign w_rem  = r_neg_r ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

  always_comb begin
    w_fix_res = w_prod[31:0];
    case (r_oper)
      3'd1, 3'd2, 3'd3: w_fix_res = w_prod[63:32];
      3'd4, 3'd5:       w_fix_res = w_quot;
      3'd6, 3'd7:       w_fix_res = w_rem;
      default:          w_fix_res = w_prod[31:0];
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_accept) w_state_next = w_fast ? StDone : StRun;
      end
      StRun: begin
        o_busy = 1'b1;
        if (r_cnt == 5'd0) w_state_next = StFix;
      end
      StFix: begin
        o_busy       = 1'b1;
        w_state_next = StDone;
      end
      StDone: begin
        o_done       = 1'b1;
        w_state_next = w_accept ? (w_fast ? StDone : StRun) : StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_oper   <= 3'd0;
      r_acc    <= 64'd0;
      r_div    <= 32'd0;
      r_cnt    <= 5'd0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= 32'd0;
    end else if (w_accept) begin
      r_oper  <= i_oper;
      r_acc   <= {32'd0, w_mag_a};
      r_div   <= w_mag_b;
      r_cnt   <= 5'd31;
      r_neg_q <= w_sign_a ^ w_sign_b;
      r_neg_r <= w_sign_a;
      if (w_fast) r_result <= w_fast_res;
    end else if (r_state == StRun) begin
      r_acc <= r_oper[2] ? w_div_next : w_mul_next;
      r_cnt <= r_cnt - 5'd1;
    end else if (r_state == StFix) begin
      r_result <= w_fix_res;
    end
  end

  assign o_result = r_result;

endmodule
